// File: rtl/logic_axi4_stream_arbiter_if.sv
// Bundle of N requesting AXI4-Stream lanes and one shared output stream.
// The arbiter takes the slave view. The requesters and the consumer take the master view.
interface logic_axi4_stream_arbiter_if #(
  parameter int INPUTS      = 4,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic [INPUTS-1:0]                       rx_tvalid;
  logic [INPUTS-1:0]                       rx_tready;
  logic [INPUTS-1:0]                       rx_tlast;
  logic [INPUTS-1:0][TDATA_BYTES-1:0][7:0] rx_tdata;
  logic [INPUTS-1:0][TDATA_BYTES-1:0]      rx_tstrb;
  logic [INPUTS-1:0][TDATA_BYTES-1:0]      rx_tkeep;
  logic [INPUTS-1:0][TDEST_WIDTH-1:0]      rx_tdest;
  logic [INPUTS-1:0][TUSER_WIDTH-1:0]      rx_tuser;
  logic [INPUTS-1:0][TID_WIDTH-1:0]        rx_tid;

  logic                        tx_tvalid;
  logic                        tx_tready;
  logic                        tx_tlast;
  logic [TDATA_BYTES-1:0][7:0] tx_tdata;
  logic [TDATA_BYTES-1:0]      tx_tstrb;
  logic [TDATA_BYTES-1:0]      tx_tkeep;
  logic [TDEST_WIDTH-1:0]      tx_tdest;
  logic [TUSER_WIDTH-1:0]      tx_tuser;
  logic [TID_WIDTH-1:0]        tx_tid;

  modport slave (
    input  rx_tvalid, rx_tlast, rx_tdata, rx_tstrb, rx_tkeep, rx_tdest, rx_tuser, rx_tid,
    output rx_tready,
    output tx_tvalid, tx_tlast, tx_tdata, tx_tstrb, tx_tkeep, tx_tdest, tx_tuser, tx_tid,
    input  tx_tready
  );

  modport master (
    output rx_tvalid, rx_tlast, rx_tdata, rx_tstrb, rx_tkeep, rx_tdest, rx_tuser, rx_tid,
    input  rx_tready,
    input  tx_tvalid, tx_tlast, tx_tdata, tx_tstrb, tx_tkeep, tx_tdest, tx_tuser, tx_tid,
    output tx_tready
  );
endinterface

// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-aware round-robin arbiter. N AXI4-Stream requesters share one registered output.
// A grant is held from the first beat of a packet through its tlast beat.
module logic_axi4_stream_arbiter #(
  parameter int INPUTS      = 4,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TLAST   = 1'b1,
  localparam int IDX_W      = $clog2(INPUTS)
) (
  input  logic                          aclk,
  input  logic                          areset,
  logic_axi4_stream_arbiter_if.slave    bus,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_index
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] sel;
  logic             any_req;
  logic             slice_ready;
  logic             xfer;
  logic             pkt_end;

  assign any_req     = |bus.rx_tvalid;
  assign slice_ready = !bus.tx_tvalid || bus.tx_tready;
  assign xfer        = (state == LOCKED) && bus.rx_tvalid[grant_index] && slice_ready;
  assign pkt_end     = xfer && (!USE_TLAST || bus.rx_tlast[grant_index]);

  // Search upward from pointer with wrap. The loop walks offsets high to low, so
  // the requester nearest to pointer is assigned last and wins.
  always_comb begin
    logic [IDX_W:0] cand;
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    sel  = pointer;
    cand = '0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      cand = {1'b0, pointer} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(INPUTS)) cand = cand - (IDX_W + 1)'(INPUTS);
      if (bus.rx_tvalid[cand[IDX_W-1:0]]) sel = cand[IDX_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = LOCKED;
      LOCKED:  if (pkt_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_tready = '0;
    if (state == LOCKED) bus.rx_tready[grant_index] = slice_ready;
    grant_valid = (state == LOCKED);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_index <= '0;
      pointer     <= '0;
    end else begin
      if (state == IDLE && any_req) grant_index <= sel;
      if (pkt_end) pointer <= (grant_index == IDX_W'(INPUTS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  // Single-entry output slice. The fields hold while a beat is stalled downstream.
  // NOTE: the data fields are reset as well, so a reset leaves the output fully zeroed.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.tx_tvalid <= 1'b0;
      bus.tx_tlast  <= 1'b0;
      bus.tx_tdata  <= '0;
      bus.tx_tstrb  <= '0;
      bus.tx_tkeep  <= '0;
      bus.tx_tdest  <= '0;
      bus.tx_tuser  <= '0;
      bus.tx_tid    <= '0;
    end else if (xfer) begin
      bus.tx_tvalid <= 1'b1;
      bus.tx_tlast  <= USE_TLAST ? bus.rx_tlast[grant_index] : 1'b1;
      bus.tx_tdata  <= bus.rx_tdata[grant_index];
      bus.tx_tstrb  <= bus.rx_tstrb[grant_index];
      bus.tx_tkeep  <= bus.rx_tkeep[grant_index];
      bus.tx_tdest  <= bus.rx_tdest[grant_index];
      bus.tx_tuser  <= bus.rx_tuser[grant_index];
      bus.tx_tid    <= bus.rx_tid[grant_index];
    end else if (bus.tx_tready) begin
      bus.tx_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Directed bench for logic_axi4_stream_arbiter. It drives a 4-lane instance with tlast,
// a 4-lane instance without tlast, and a 3-lane instance for the pointer wrap.
module tb_logic_axi4_stream_arbiter;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic_axi4_stream_arbiter_if #(.INPUTS(4)) m_if ();
  logic_axi4_stream_arbiter_if #(.INPUTS(4)) nl_if ();
  logic_axi4_stream_arbiter_if #(.INPUTS(3)) w3_if ();

  logic       m_gv, nl_gv, w3_gv;
  logic [1:0] m_gi, nl_gi, w3_gi;

  logic_axi4_stream_arbiter #(.INPUTS(4), .USE_TLAST(1'b1)) u_dut (
    .aclk(aclk), .areset(areset), .bus(m_if.slave), .grant_valid(m_gv), .grant_index(m_gi));
  logic_axi4_stream_arbiter #(.INPUTS(4), .USE_TLAST(1'b0)) u_nl (
    .aclk(aclk), .areset(areset), .bus(nl_if.slave), .grant_valid(nl_gv), .grant_index(nl_gi));
  logic_axi4_stream_arbiter #(.INPUTS(3), .USE_TLAST(1'b1)) u_w3 (
    .aclk(aclk), .areset(areset), .bus(w3_if.slave), .grant_valid(w3_gv), .grant_index(w3_gi));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  // Lanes continuously offer packets of pkt_len beats. Lane data is encoded as
  // lane*256 + packet*16 + beat. The expected output order is round-robin over
  // the active lanes, starting from lane 0 after reset.
  task automatic run_traffic(input logic [3:0] active, input int pkt_len, input int exp_n, input bit bp);
    int          beat [4];
    int          pkt  [4];
    int          lanes[$];
    logic [3:0]  hs;
    int          n;
    bit          prev_stall;
    logic [31:0] prev_data;
    int          p, b, ln;
    for (int l = 0; l < 4; l++) begin
      beat[l] = 0;
      pkt[l]  = 0;
      if (active[l]) lanes.push_back(l);
    end
    hs = '0; n = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && n < exp_n; cyc++) begin
      for (int l = 0; l < 4; l++) begin
        if (hs[l]) begin
          if (beat[l] == pkt_len - 1) begin beat[l] = 0; pkt[l]++; end
          else beat[l]++;
        end
        m_if.rx_tvalid[l] = active[l];
        m_if.rx_tdata[l]  = 32'(l * 256 + pkt[l] * 16 + beat[l]);
        m_if.rx_tlast[l]  = (beat[l] == pkt_len - 1);
      end
      m_if.tx_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (m_if.tx_tvalid && !m_if.tx_tready) check("bp_rx_tready_low", 64'(m_if.rx_tready), 64'h0);
      if (prev_stall) check("stall_data_hold", 64'(m_if.tx_tdata), 64'(prev_data));
      if (m_if.tx_tvalid && m_if.tx_tready) begin
        p  = n / pkt_len;
        b  = n % pkt_len;
        ln = lanes[p % lanes.size()];
        check($sformatf("seq_data[%0d]", n), 64'(m_if.tx_tdata), 64'(ln * 256 + (p / lanes.size()) * 16 + b));
        check($sformatf("seq_tlast[%0d]", n), 64'(m_if.tx_tlast), 64'(b == pkt_len - 1));
        n++;
      end
      prev_stall = m_if.tx_tvalid && !m_if.tx_tready;
      prev_data  = m_if.tx_tdata;
      hs = m_if.rx_tvalid & m_if.rx_tready;
      step();
    end
    check("traffic_beat_count", 64'(n), 64'(exp_n));
    m_if.rx_tvalid = '0;
    m_if.tx_tready = 1'b1;
  endtask

  initial begin
    int          n;
    logic [31:0] exp_lane [4];
    m_if.rx_tvalid = '0;  m_if.rx_tlast = '0;  m_if.rx_tdata = '0;  m_if.rx_tstrb = '0;
    m_if.rx_tkeep  = '0;  m_if.rx_tdest = '0;  m_if.rx_tuser = '0;  m_if.rx_tid   = '0;
    m_if.tx_tready = 1'b1;
    nl_if.rx_tvalid = '0; nl_if.rx_tlast = '0; nl_if.rx_tdata = '0; nl_if.rx_tstrb = '0;
    nl_if.rx_tkeep  = '0; nl_if.rx_tdest = '0; nl_if.rx_tuser = '0; nl_if.rx_tid   = '0;
    nl_if.tx_tready = 1'b1;
    w3_if.rx_tvalid = '0; w3_if.rx_tlast = '0; w3_if.rx_tdata = '0; w3_if.rx_tstrb = '0;
    w3_if.rx_tkeep  = '0; w3_if.rx_tdest = '0; w3_if.rx_tuser = '0; w3_if.rx_tid   = '0;
    w3_if.tx_tready = 1'b1;

    do_reset();
    check("reset_tx_tvalid", 64'(m_if.tx_tvalid), 64'h0);
    check("reset_tx_tlast", 64'(m_if.tx_tlast), 64'h0);
    check("reset_tx_tdata", 64'(m_if.tx_tdata), 64'h0);
    check("reset_rx_tready", 64'(m_if.rx_tready), 64'h0);
    check("reset_grant_valid", 64'(m_gv), 64'h0);
    check("reset_grant_index", 64'(m_gi), 64'h0);

    // Single requester: lane 2 sends a 3-beat packet.
    m_if.rx_tvalid[2] = 1'b1; m_if.rx_tdata[2] = 32'hA0; m_if.rx_tlast[2] = 1'b0;
    m_if.rx_tkeep[2]  = 4'hF;
    #1;
    check("idle_rx_tready", 64'(m_if.rx_tready), 64'h0);
    step();
    check("lock_grant_valid", 64'(m_gv), 64'h1);
    check("lock_grant_index", 64'(m_gi), 64'h2);
    check("lock_rx_tready", 64'(m_if.rx_tready), 64'b0100);
    check("lock_tx_tvalid", 64'(m_if.tx_tvalid), 64'h0);
    step();
    check("beat0_tvalid", 64'(m_if.tx_tvalid), 64'h1);
    check("beat0_tdata", 64'(m_if.tx_tdata), 64'hA0);
    check("beat0_tkeep", 64'(m_if.tx_tkeep), 64'hF);
    check("beat0_tlast", 64'(m_if.tx_tlast), 64'h0);
    m_if.rx_tdata[2] = 32'hA1;
    step();
    check("beat1_tdata", 64'(m_if.tx_tdata), 64'hA1);
    m_if.rx_tdata[2] = 32'hA2; m_if.rx_tlast[2] = 1'b1;
    step();
    check("beat2_tdata", 64'(m_if.tx_tdata), 64'hA2);
    check("beat2_tlast", 64'(m_if.tx_tlast), 64'h1);
    check("end_grant_valid", 64'(m_gv), 64'h0);
    check("end_pointer", 64'(u_dut.pointer), 64'h3);
    m_if.rx_tvalid = '0; m_if.rx_tlast = '0;
    step();
    check("drain_tx_tvalid", 64'(m_if.tx_tvalid), 64'h0);
    check("hold_grant_index", 64'(m_gi), 64'h2);

    // Fairness across all four lanes, then backpressure on a single lane.
    do_reset();
    run_traffic(4'b1111, 2, 16, 1'b0);
    do_reset();
    run_traffic(4'b0010, 4, 8, 1'b1);

    // Reset in the middle of a packet on lane 2.
    do_reset();
    m_if.rx_tvalid[2] = 1'b1; m_if.rx_tdata[2] = 32'hB0; m_if.rx_tlast[2] = 1'b0;
    step();
    step();
    check("mid_tx_tvalid", 64'(m_if.tx_tvalid), 64'h1);
    m_if.rx_tdata[2] = 32'hB1;
    areset = 1'b1;
    step();
    check("rst_mid_tx_tvalid", 64'(m_if.tx_tvalid), 64'h0);
    check("rst_mid_tx_tdata", 64'(m_if.tx_tdata), 64'h0);
    check("rst_mid_rx_tready", 64'(m_if.rx_tready), 64'h0);
    check("rst_mid_grant_valid", 64'(m_gv), 64'h0);
    check("rst_mid_grant_index", 64'(m_gi), 64'h0);
    areset = 1'b0;
    m_if.rx_tvalid = 4'b1001;
    step();
    check("post_rst_grant_valid", 64'(m_gv), 64'h1);
    check("post_rst_grant_index", 64'(m_gi), 64'h0);
    m_if.rx_tvalid = '0;
    do_reset();

    // Without tlast: lanes 1 and 3 alternate with single beats, and every beat carries tlast.
    exp_lane[0] = 32'h11; exp_lane[1] = 32'h33; exp_lane[2] = 32'h11; exp_lane[3] = 32'h33;
    nl_if.rx_tvalid = 4'b1010;
    nl_if.rx_tdata[1] = 32'h11;
    nl_if.rx_tdata[3] = 32'h33;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      if (nl_if.tx_tvalid) begin
        check($sformatf("nl_data[%0d]", n), 64'(nl_if.tx_tdata), 64'(exp_lane[n]));
        check($sformatf("nl_tlast[%0d]", n), 64'(nl_if.tx_tlast), 64'h1);
        n++;
      end
      step();
    end
    check("nl_beat_count", 64'(n), 64'h4);
    nl_if.rx_tvalid = '0;

    // Three lanes: a lane-1 packet moves pointer to 2. Lanes 0 and 2 then show the wrap.
    w3_if.rx_tdata[0] = 32'hC0; w3_if.rx_tdata[1] = 32'hC1; w3_if.rx_tdata[2] = 32'hC2;
    w3_if.rx_tlast = 3'b111;
    w3_if.rx_tvalid = 3'b010;
    step();
    check("w3_first_grant", 64'(w3_gi), 64'h1);
    step();
    w3_if.rx_tvalid = 3'b000;
    check("w3_pointer_2", 64'(u_w3.pointer), 64'h2);
    w3_if.rx_tvalid = 3'b101;
    step();
    check("w3_grant_lane2", 64'(w3_gi), 64'h2);
    step();
    check("w3_pointer_wrap_0", 64'(u_w3.pointer), 64'h0);
    check("w3_tx_lane2", 64'(w3_if.tx_tdata), 64'hC2);
    step();
    check("w3_grant_lane0", 64'(w3_gi), 64'h0);
    step();
    check("w3_pointer_1", 64'(u_w3.pointer), 64'h1);
    check("w3_tx_lane0", 64'(w3_if.tx_tdata), 64'hC0);
    w3_if.rx_tvalid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
